assoc_learning_unit: RTL and testbench

- Associative layer stage directly downstream of the memory layer controller.
- Learning: after the memory layer settles a key/response class pair, the controller raises assoc_learning_start. This block then strengthens the existing key->response edge, or creates the edge if it is absent, and returns assoc_learning_done.
- Recall: returns the response class with the heaviest edge for a given key class.
- The edge table is internal, held in flops, and scanned one entry per cycle.

---
 rtl/assoc_learning_unit_pkg.sv | 36 +++
 rtl/assoc_learning_unit_if.sv | 36 +++
 rtl/assoc_learning_unit_edge_table.sv | 32 +++
 rtl/assoc_learning_unit.sv | 209 ++++++++++++++++++++
 tb/tb_assoc_learning_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/assoc_learning_unit_pkg.sv
// Shared types and defaults for the associative learning stage that sits
// after the memory layer controller.
package assoc_learning_unit_pkg;

    localparam int ASSOC_CLS_W     = 4;
    localparam int ASSOC_MAX_EDGES = 32;
    localparam int ASSOC_WEIGHT_W  = 8;

    typedef enum logic {
        LEARNING = 1'b0,
        RECALL   = 1'b1
    } LEARNING_RECALL_T;

    typedef enum logic [2:0] {
        IDLE,
        L_SCAN,
        L_UPDATE,
        L_CREATE,
        L_DONE,
        R_SCAN,
        R_DONE
    } ASSOC_STATE_T;

    typedef struct packed {
        logic                      valid;
        logic [ASSOC_CLS_W-1:0]    key;
        logic [ASSOC_CLS_W-1:0]    resp;
        logic [ASSOC_WEIGHT_W-1:0] weight;
    } assoc_edge_T;

    // Weights stick at full scale instead of wrapping back to zero.
    function automatic logic [ASSOC_WEIGHT_W-1:0] sat_inc(input logic [ASSOC_WEIGHT_W-1:0] w);
        return (w == {ASSOC_WEIGHT_W{1'b1}}) ? w : w + ASSOC_WEIGHT_W'(1);
    endfunction

endpackage

// File: rtl/assoc_learning_unit_if.sv
// Request/response bundle between the memory layer controller (master) and
// the associative learning unit (slave).
interface assoc_learning_unit_if
    import assoc_learning_unit_pkg::*;
#(
    parameter int CLS_W = ASSOC_CLS_W,
    parameter int CNT_W = $clog2(ASSOC_MAX_EDGES) + 1
);

    LEARNING_RECALL_T   learning_recall;
    logic               assoc_learning_start;
    logic [CLS_W-1:0]   key_class;
    logic [CLS_W-1:0]   resp_class;
    logic               recall_req;

    logic               assoc_learning_done;
    logic               learn_dropped;
    logic               recall_valid;
    logic               recall_found;
    logic [CLS_W-1:0]   recall_class;
    logic [CNT_W-1:0]   edge_count;
    logic               busy;

    modport master (
        output learning_recall, assoc_learning_start, key_class, resp_class, recall_req,
        input  assoc_learning_done, learn_dropped, recall_valid, recall_found,
               recall_class, edge_count, busy
    );

    modport slave (
        input  learning_recall, assoc_learning_start, key_class, resp_class, recall_req,
        output assoc_learning_done, learn_dropped, recall_valid, recall_found,
               recall_class, edge_count, busy
    );

endinterface

// File: rtl/assoc_learning_unit_edge_table.sv
// Flop-based edge table: one combinational read port, one synchronous write
// port, and a full clear while reset is held.
module assoc_edge_table
    import assoc_learning_unit_pkg::*;
#(
    parameter int DEPTH = ASSOC_MAX_EDGES,
    parameter int IDX_W = $clog2(ASSOC_MAX_EDGES)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output assoc_edge_T      rd_entry,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  assoc_edge_T      wr_entry
);

    assoc_edge_T table_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (we) begin
            table_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = table_q[rd_idx];

endmodule

// File: rtl/assoc_learning_unit.sv
// Associative layer: strengthens or creates key->response edges on learn and
// returns the heaviest response for a key on recall, scanning one entry per cycle.
module assoc_learning_unit
    import assoc_learning_unit_pkg::*;
#(
    parameter int CLS_W     = ASSOC_CLS_W,
    parameter int MAX_EDGES = ASSOC_MAX_EDGES,
    parameter int WEIGHT_W  = ASSOC_WEIGHT_W
)(
    input logic                 clk,
    input logic                 reset,
    assoc_learning_unit_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_EDGES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_EDGES - 1);

    ASSOC_STATE_T state, state_next;

    logic [IDX_W-1:0]    cnt;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    free_idx;
    logic                free_found;
    logic                drop_flag;
    logic [CLS_W-1:0]    key_q;
    logic [CLS_W-1:0]    resp_q;
    logic                best_found;
    logic [WEIGHT_W-1:0] best_w;
    logic [CLS_W-1:0]    best_class;

    logic [CNT_W-1:0]    edge_count_q;
    logic                done_q;
    logic                dropped_q;
    logic                recall_valid_q;
    logic                recall_found_q;
    logic [CLS_W-1:0]    recall_class_q;

    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    assoc_edge_T         rd_entry;
    assoc_edge_T         wr_entry;
    logic                we;

    logic accept_learn, accept_recall;
    logic key_match, pair_match, free_here, best_take;

    assoc_edge_table #(
        .DEPTH (MAX_EDGES),
        .IDX_W (IDX_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .we       (we),
        .wr_idx   (wr_idx),
        .wr_entry (wr_entry)
    );

    always_comb begin
        accept_learn  = (bus.learning_recall == LEARNING) && bus.assoc_learning_start;
        accept_recall = (bus.learning_recall == RECALL) && bus.recall_req;
        key_match     = rd_entry.valid && (rd_entry.key == key_q);
        pair_match    = key_match && (rd_entry.resp == resp_q);
        free_here     = !rd_entry.valid;
        // Strictly greater keeps the lowest-index entry on equal weights.
        best_take     = key_match && (!best_found || (rd_entry.weight > best_w));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_idx     = cnt;
        we         = 1'b0;
        wr_idx     = cnt;
        wr_entry   = '0;
        case (state)
            IDLE: begin
                if (accept_learn) begin
                    state_next = L_SCAN;
                end else if (accept_recall) begin
                    state_next = R_SCAN;
                end
            end
            L_SCAN: begin
                if (pair_match) begin
                    state_next = L_UPDATE;
                end else if (cnt == LAST_IDX) begin
                    state_next = (free_found || free_here) ? L_CREATE : L_DONE;
                end
            end
            L_UPDATE: begin
                rd_idx          = hit_idx;
                we              = 1'b1;
                wr_idx          = hit_idx;
                wr_entry        = rd_entry;
                wr_entry.weight = sat_inc(rd_entry.weight);
                state_next      = L_DONE;
            end
            L_CREATE: begin
                we              = 1'b1;
                wr_idx          = free_idx;
                wr_entry.valid  = 1'b1;
                wr_entry.key    = key_q;
                wr_entry.resp   = resp_q;
                wr_entry.weight = WEIGHT_W'(1);
                state_next      = L_DONE;
            end
            L_DONE: state_next = IDLE;
            R_SCAN: begin
                if (cnt == LAST_IDX) begin
                    state_next = R_DONE;
                end
            end
            R_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan bookkeeping plus registered result pulses; a reset drops any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            hit_idx        <= '0;
            free_idx       <= '0;
            free_found     <= 1'b0;
            drop_flag      <= 1'b0;
            key_q          <= '0;
            resp_q         <= '0;
            best_found     <= 1'b0;
            best_w         <= '0;
            best_class     <= '0;
            edge_count_q   <= '0;
            done_q         <= 1'b0;
            dropped_q      <= 1'b0;
            recall_valid_q <= 1'b0;
            recall_found_q <= 1'b0;
            recall_class_q <= '0;
        end else begin
            done_q         <= (state == L_DONE);
            dropped_q      <= (state == L_DONE) && drop_flag;
            recall_valid_q <= (state == R_DONE);
            case (state)
                IDLE: begin
                    if (accept_learn || accept_recall) begin
                        key_q      <= bus.key_class;
                        cnt        <= '0;
                        free_found <= 1'b0;
                        drop_flag  <= 1'b0;
                        best_found <= 1'b0;
                        best_w     <= '0;
                        best_class <= '0;
                    end
                    if (accept_learn) begin
                        resp_q <= bus.resp_class;
                    end
                end
                L_SCAN: begin
                    if (pair_match) begin
                        hit_idx <= cnt;
                    end else begin
                        if (free_here && !free_found) begin
                            free_idx   <= cnt;
                            free_found <= 1'b1;
                        end
                        if (cnt == LAST_IDX) begin
                            drop_flag <= !(free_found || free_here);
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                L_CREATE: edge_count_q <= edge_count_q + CNT_W'(1);
                R_SCAN: begin
                    if (best_take) begin
                        best_found <= 1'b1;
                        best_w     <= rd_entry.weight;
                        best_class <= rd_entry.resp;
                    end
                    if (cnt != LAST_IDX) begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                R_DONE: begin
                    recall_found_q <= best_found;
                    recall_class_q <= best_found ? best_class : '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.assoc_learning_done = done_q;
    assign bus.learn_dropped       = dropped_q;
    assign bus.recall_valid        = recall_valid_q;
    assign bus.recall_found        = recall_found_q;
    assign bus.recall_class        = recall_class_q;
    assign bus.edge_count          = edge_count_q;
    assign bus.busy                = (state != IDLE);

endmodule

// File: tb/tb_assoc_learning_unit.sv
// Directed bench for assoc_learning_unit: an insertion-ordered edge list models
// the table, and a negedge monitor checks every result pulse against it.
module tb_assoc_learning_unit;
    import assoc_learning_unit_pkg::*;

    localparam int MAX  = 32;
    localparam int WMAX = 255;

    logic clk;
    logic reset;

    assoc_learning_unit_if #(.CLS_W(4), .CNT_W(6)) bus();

    assoc_learning_unit #(
        .CLS_W     (4),
        .MAX_EDGES (MAX),
        .WEIGHT_W  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] key;
        logic [3:0] resp;
        int         weight;
    } medge_t;

    // With no eviction, edges occupy slots in creation order, so queue position == table index.
    medge_t mq[$];

    int checksTotal  = 0;
    int checksPassed = 0;
    bit armLearn     = 1'b0;
    bit armRecall    = 1'b0;
    int expDrop      = 0;
    int expCount     = 0;
    int expFound     = 0;
    int expClass     = 0;
    int lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checksTotal++;
        if (act == exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Result pulses must be announced by a request; idle edge_count must track the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.assoc_learning_done) begin
                checkOutput("done_expected", int'(armLearn), 1);
                if (armLearn) begin
                    checkOutput("learn_dropped", int'(bus.learn_dropped), expDrop);
                    checkOutput("edge_count_at_done", int'(bus.edge_count), expCount);
                end
            end else begin
                checkOutput("dropped_low", int'(bus.learn_dropped), 0);
            end
            if (bus.recall_valid) begin
                checkOutput("recall_expected", int'(armRecall), 1);
                if (armRecall) begin
                    checkOutput("recall_found", int'(bus.recall_found), expFound);
                    checkOutput("recall_class", int'(bus.recall_class), expClass);
                end
            end
            if (!bus.busy && !armLearn && !armRecall) begin
                checkOutput("edge_count_idle", int'(bus.edge_count), mq.size());
            end
        end
    end

    task automatic applyStimulus(input bit isLearn, input logic [3:0] k, input logic [3:0] r,
                                 input bit inject, output int latency);
        int hit;
        int best;
        int expLat;
        bit seen;
        hit    = -1;
        expLat = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (hit < 0 && mq[i].key == k && mq[i].resp == r) hit = i;
        end
        if (isLearn) begin
            expDrop  = 0;
            expCount = mq.size();
            if (hit >= 0) begin
                expLat = 3 + hit;
            end else if (mq.size() < MAX) begin
                expLat   = 2 + MAX;
                expCount = mq.size() + 1;
            end else begin
                expDrop = 1;
            end
        end else begin
            best     = 0;
            expFound = 0;
            expClass = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].key == k && mq[i].weight > best) begin
                    best     = mq[i].weight;
                    expFound = 1;
                    expClass = int'(mq[i].resp);
                end
            end
        end

        @(negedge clk);
        bus.learning_recall = isLearn ? LEARNING : RECALL;
        bus.key_class       = k;
        bus.resp_class      = r;
        bus.assoc_learning_start = isLearn;
        bus.recall_req           = !isLearn;
        armLearn  = isLearn;
        armRecall = !isLearn;
        @(posedge clk);
        #1;
        bus.assoc_learning_start = 1'b0;
        bus.recall_req           = 1'b0;

        seen    = 1'b0;
        latency = 0;
        for (int n = 1; n <= 2 * MAX + 8 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (isLearn ? bus.assoc_learning_done : bus.recall_valid) begin
                seen    = 1'b1;
                latency = n;
            end
            bus.assoc_learning_start = inject && (n == 4);
            if (inject && n == 4) begin
                bus.key_class  = k + 4'd1;
                bus.resp_class = r + 4'd1;
            end
        end
        bus.assoc_learning_start = 1'b0;

        checkOutput(isLearn ? "learn_timeout" : "recall_timeout", int'(seen), 1);
        if (isLearn && expLat != 0) begin
            checkOutput("learn_latency", latency, expLat);
        end else if (isLearn) begin
            checkOutput("drop_latency_bound", int'(latency > 0 && latency <= 2 + MAX), 1);
        end else begin
            checkOutput("recall_latency_bound", int'(latency >= MAX + 1 && latency <= MAX + 2), 1);
        end

        @(negedge clk);
        #1;
        armLearn  = 1'b0;
        armRecall = 1'b0;
        if (isLearn && expDrop == 0) begin
            if (hit >= 0) begin
                mq[hit].weight = (mq[hit].weight >= WMAX) ? WMAX : mq[hit].weight + 1;
            end else begin
                mq.push_back('{key: k, resp: r, weight: 1});
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        mq.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset                    = 1'b1;
        bus.learning_recall      = LEARNING;
        bus.assoc_learning_start = 1'b0;
        bus.recall_req           = 1'b0;
        bus.key_class            = '0;
        bus.resp_class           = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_done",         int'(bus.assoc_learning_done), 0);
        checkOutput("rst_dropped",      int'(bus.learn_dropped), 0);
        checkOutput("rst_recall_valid", int'(bus.recall_valid), 0);
        checkOutput("rst_recall_found", int'(bus.recall_found), 0);
        checkOutput("rst_recall_class", int'(bus.recall_class), 0);
        checkOutput("rst_edge_count",   int'(bus.edge_count), 0);
        checkOutput("rst_busy",         int'(bus.busy), 0);

        // First learn creates entry 0; repeats hit at index 0.
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, lat);
        checkOutput("lit_create_latency", lat, 34);
        checkOutput("lit_count_one", int'(bus.edge_count), 1);
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, lat);
        checkOutput("lit_hit0_latency", lat, 3);
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, lat);
        checkOutput("lit_count_still_one", int'(bus.edge_count), 1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd3, 4'd9, 1'b0, lat);
        checkOutput("lit_hit1_latency", lat, 4);

        applyStimulus(1'b0, 4'd3, 4'd0, 1'b0, lat);
        checkOutput("lit_tie_found", int'(bus.recall_found), 1);
        checkOutput("lit_tie_class", int'(bus.recall_class), 5);
        applyStimulus(1'b1, 4'd3, 4'd9, 1'b0, lat);
        applyStimulus(1'b0, 4'd3, 4'd0, 1'b0, lat);
        checkOutput("lit_heavier_class", int'(bus.recall_class), 9);
        applyStimulus(1'b0, 4'd7, 4'd0, 1'b0, lat);
        checkOutput("lit_absent_found", int'(bus.recall_found), 0);
        checkOutput("lit_absent_class", int'(bus.recall_class), 0);

        // A second start during the scan of (4,4) must not create (5,5).
        applyStimulus(1'b1, 4'd4, 4'd4, 1'b1, lat);
        checkOutput("lit_count_after_inject", int'(bus.edge_count), 3);
        applyStimulus(1'b0, 4'd5, 4'd0, 1'b0, lat);
        checkOutput("lit_inject_not_learned", int'(bus.recall_found), 0);

        // Requests of the non-selected kind are ignored.
        @(negedge clk);
        bus.learning_recall = LEARNING;
        bus.key_class       = 4'd3;
        bus.recall_req      = 1'b1;
        @(negedge clk);
        bus.recall_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("recall_req_ignored", int'(bus.busy), 0);
        end
        bus.learning_recall      = RECALL;
        bus.resp_class           = 4'd1;
        bus.assoc_learning_start = 1'b1;
        @(negedge clk);
        bus.assoc_learning_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("start_ignored", int'(bus.busy), 0);
        end

        // Reset in the middle of a learn scan aborts it silently.
        @(negedge clk);
        bus.learning_recall      = LEARNING;
        bus.key_class            = 4'd9;
        bus.resp_class           = 4'd9;
        bus.assoc_learning_start = 1'b1;
        @(negedge clk);
        bus.assoc_learning_start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_in_scan", int'(bus.busy), 1);
        mq.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_edge_count", int'(bus.edge_count), 0);
        repeat (40) @(negedge clk);
        applyStimulus(1'b0, 4'd9, 4'd0, 1'b0, lat);
        checkOutput("lit_abort_not_learned", int'(bus.recall_found), 0);

        // Fill the table, then a new pair is dropped and existing pairs still strengthen.
        doReset();
        for (int i = 0; i < MAX; i++) begin
            applyStimulus(1'b1, 4'(i % 16), 4'(i / 16), 1'b0, lat);
        end
        checkOutput("lit_full_count", int'(bus.edge_count), 32);
        applyStimulus(1'b1, 4'd15, 4'd15, 1'b0, lat);
        checkOutput("lit_full_count_after_drop", int'(bus.edge_count), 32);
        applyStimulus(1'b0, 4'd15, 4'd0, 1'b0, lat);
        checkOutput("lit_full_recall_class", int'(bus.recall_class), 0);
        applyStimulus(1'b1, 4'd0, 4'd1, 1'b0, lat);
        checkOutput("lit_full_hit16_latency", lat, 19);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, lat);
        checkOutput("lit_full_strengthened", int'(bus.recall_class), 1);

        // Saturation: 300 learns hold at 255, tying with a second edge at 255.
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, lat);
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 4'd1, 4'd3, 1'b0, lat);
        applyStimulus(1'b0, 4'd1, 4'd0, 1'b0, lat);
        checkOutput("lit_saturated_tie_found", int'(bus.recall_found), 1);
        checkOutput("lit_saturated_tie_class", int'(bus.recall_class), 2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
